ifft8_stream: RTL and testbench

- Serial 8-point radix-2 decimation-in-time inverse FFT: the return path for fft8 spectra.
- Accepts 8 complex frequency bins over a valid/ready stream and runs 3 butterfly stages in place, one butterfly per cycle.
- Applies 1/8 scaling, one halving per stage.
- Streams 8 complex time-domain samples out over a valid/ready stream, for the post-processing path after spectral modification.

---
 rtl/ifft8_stream_if.sv | 24 ++
 rtl/ifft8_stream.sv | 204 ++++++++++++++++++++
 tb/tb_ifft8_stream.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifft8_stream_if.sv
// rtl/ifft8_stream_if.sv - bin input and sample output valid/ready streams of ifft8_stream
interface ifft8_stream_if #(
    parameter int DW = 16
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic                 out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last
    );
endinterface

// File: rtl/ifft8_stream.sv
// rtl/ifft8_stream.sv - serial 8-point radix-2 DIT inverse FFT with 1/8 scaling, one butterfly per cycle
module ifft8_stream #(
    parameter int DW = 16,
    parameter int TW = 14
) (
    input  logic           clk,
    input  logic           rst,
    ifft8_stream_if.slave  s,
    output logic           busy
);
    localparam int PW = 2 * DW + 2;
    // round(0.70710678 * 2^TW) via 46341/2^16, kept in 64 bits so wide TW cannot overflow
    localparam logic [63:0]          COS45_U = ((64'd46341 << TW) + 64'd32768) >> 16;
    localparam logic signed [PW-1:0] COS45   = PW'(COS45_U);
    localparam logic signed [PW-1:0] SAT_MAX = PW'((64'd1 << (DW - 1)) - 64'd1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t               state_q;
    logic [2:0]           k_q;
    logic [3:0]           bf_q;
    logic [2:0]           n_q;
    logic [2:0]           n_d;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic                 busy_q;
    logic signed [DW-1:0] out_re_q;
    logic signed [DW-1:0] out_im_q;

    logic signed [DW-1:0] buf_re_q [8];
    logic signed [DW-1:0] buf_im_q [8];

    logic                 accept;
    logic [2:0]           wr_addr;
    logic [2:0]           a_addr;
    logic [2:0]           b_addr;
    logic [1:0]           tw_idx;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic signed [PW-1:0] br_x, bi_x, mr, mi, f_re, f_im, sh_re, sh_im;
    logic signed [DW-1:0] sat_re, sat_im;
    logic signed [DW:0]   p_re, p_im;
    logic signed [DW+1:0] sum_re, sum_im, dif_re, dif_im;
    logic signed [DW-1:0] na_re, na_im, nb_re, nb_im;

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)      return DW'(SAT_MAX);
        else if (v < SAT_MIN) return DW'(SAT_MIN);
        else                  return DW'(v);
    endfunction

    assign accept  = (state_q == LOAD) && in_ready_q && s.in_valid;
    assign wr_addr = {k_q[0], k_q[1], k_q[2]};
    assign n_d     = n_q + 3'd1;

    // bf_q[3:2] is the stage (span 1,2,4), bf_q[1:0] the butterfly within it, top index ascending
    always_comb begin
        a_addr = '0;
        tw_idx = '0;
        case (bf_q[3:2])
            2'd0: begin
                a_addr = {bf_q[1:0], 1'b0};
                tw_idx = 2'd0;
            end
            2'd1: begin
                a_addr = {bf_q[1], 1'b0, bf_q[0]};
                tw_idx = {bf_q[0], 1'b0};
            end
            default: begin
                a_addr = {1'b0, bf_q[1:0]};
                tw_idx = bf_q[1:0];
            end
        endcase
        b_addr = a_addr | (3'd1 << bf_q[3:2]);
    end

    assign a_re = buf_re_q[a_addr];
    assign a_im = buf_im_q[a_addr];
    assign b_re = buf_re_q[b_addr];
    assign b_im = buf_im_q[b_addr];

    always_comb begin
        br_x = {{(PW - DW){b_re[DW-1]}}, b_re};
        bi_x = {{(PW - DW){b_im[DW-1]}}, b_im};
        mr   = br_x * COS45;
        mi   = bi_x * COS45;
        // tw_idx[1] selects (-c,+c) over (c,+c)
        if (tw_idx[1]) begin
            f_re = -(mr + mi);
            f_im = mr - mi;
        end else begin
            f_re = mr - mi;
            f_im = mr + mi;
        end
        sh_re  = f_re >>> TW;
        sh_im  = f_im >>> TW;
        sat_re = sat_dw(sh_re);
        sat_im = sat_dw(sh_im);

        // p carries one extra bit so that +j times -2^(DW-1) is exact
        case (tw_idx)
            2'd0: begin
                p_re = {b_re[DW-1], b_re};
                p_im = {b_im[DW-1], b_im};
            end
            2'd2: begin
                p_re = -{b_im[DW-1], b_im};
                p_im = {b_re[DW-1], b_re};
            end
            default: begin
                p_re = {sat_re[DW-1], sat_re};
                p_im = {sat_im[DW-1], sat_im};
            end
        endcase

        sum_re = {{2{a_re[DW-1]}}, a_re} + {p_re[DW], p_re};
        sum_im = {{2{a_im[DW-1]}}, a_im} + {p_im[DW], p_im};
        dif_re = {{2{a_re[DW-1]}}, a_re} - {p_re[DW], p_re};
        dif_im = {{2{a_im[DW-1]}}, a_im} - {p_im[DW], p_im};
        na_re  = DW'(sum_re >>> 1);
        na_im  = DW'(sum_im >>> 1);
        nb_re  = DW'(dif_re >>> 1);
        nb_im  = DW'(dif_im >>> 1);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_re_q[wr_addr] <= s.in_re;
            buf_im_q[wr_addr] <= s.in_im;
        end else if (state_q == COMPUTE) begin
            buf_re_q[a_addr] <= na_re;
            buf_im_q[a_addr] <= na_im;
            buf_re_q[b_addr] <= nb_re;
            buf_im_q[b_addr] <= nb_im;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            k_q         <= '0;
            bf_q        <= '0;
            n_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        k_q <= k_q + 3'd1;
                        if (k_q == 3'd7) begin
                            state_q    <= COMPUTE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            bf_q       <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    bf_q <= bf_q + 4'd1;
                    if (bf_q == 4'd11) begin
                        state_q <= UNLOAD;
                        n_q     <= '0;
                    end
                end
                UNLOAD: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_re_q    <= buf_re_q[n_q];
                        out_im_q    <= buf_im_q[n_q];
                        out_last_q  <= (n_q == 3'd7);
                    end else if (s.out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            state_q     <= LOAD;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            n_q         <= '0;
                        end else begin
                            n_q        <= n_d;
                            out_re_q   <= buf_re_q[n_d];
                            out_im_q   <= buf_im_q[n_d];
                            out_last_q <= (n_d == 3'd7);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.out_re    = out_re_q;
    assign s.out_im    = out_im_q;
    assign s.out_last  = out_last_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_ifft8_stream.sv
// tb/tb_ifft8_stream.sv - self-checking bench for ifft8_stream against a loop-based IDFT reference
module tb_ifft8_stream;
    localparam int DW = 16;
    localparam int C45 = 11585;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_fail = 0;

    ifft8_stream_if #(.DW(DW)) s ();

    ifft8_stream #(.DW(DW), .TW(14)) dut (
        .clk  (clk),
        .rst  (rst),
        .s    (s),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic int brev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // In-place radix-2 DIT IDFT on bit-reversed data, halving after every stage
    task automatic ref_ifft(input int xr[8], input int xi[8], output int yr[8], output int yi[8]);
        int pr, pi, b, t;
        for (int k = 0; k < 8; k++) begin
            yr[brev3(k)] = xr[k];
            yi[brev3(k)] = xi[k];
        end
        for (int h = 1; h < 8; h = h * 2) begin
            for (int a = 0; a < 8; a++) begin
                if ((a & h) == 0) begin
                    b = a + h;
                    t = (a % h) * (4 / h);
                    case (t)
                        0: begin pr = yr[b]; pi = yi[b]; end
                        2: begin pr = -yi[b]; pi = yr[b]; end
                        1: begin
                            pr = sat16((longint'(C45) * (yr[b] - yi[b])) >>> 14);
                            pi = sat16((longint'(C45) * (yr[b] + yi[b])) >>> 14);
                        end
                        default: begin
                            pr = sat16((-longint'(C45) * (yr[b] + yi[b])) >>> 14);
                            pi = sat16((longint'(C45) * (yr[b] - yi[b])) >>> 14);
                        end
                    endcase
                    {yr[b], yi[b]} = {(yr[a] - pr) >>> 1, (yi[a] - pi) >>> 1};
                    {yr[a], yi[a]} = {(yr[a] + pr) >>> 1, (yi[a] + pi) >>> 1};
                end
            end
        end
    endtask

    task automatic rand_frame(output int xr[8], output int xi[8]);
        for (int k = 0; k < 8; k++) begin
            xr[k] = int'($urandom_range(65535)) - 32768;
            xi[k] = int'($urandom_range(65535)) - 32768;
        end
    endtask

    // Returns just after the edge that accepts bin 7; ok=0 if in_ready never came
    task automatic send_frame(input int xr[8], input int xi[8], input bit gapped, output bit ok);
        int w;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s.in_valid = 1'b1;
            s.in_re    = 16'(xr[k]);
            s.in_im    = 16'(xi[k]);
            w = 0;
            while (s.in_ready !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) ok = 1'b0;
            @(posedge clk);
            if (gapped && k < 7) begin
                @(negedge clk);
                s.in_valid = 1'b0;
            end
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1-0-0-1, 2: random ready
    task automatic collect(input int mode, input bit hold, output int yr[8], output int yi[8],
                           output logic [7:0] lastm, output int hs, output int stall_viol,
                           output int ready_viol, output int first_cyc, output bit timeout);
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit rdy, prev_stall;
        logic signed [DW-1:0] h_re, h_im;
        logic h_last;
        int cyc, extra, hs0;
        hs = 0; stall_viol = 0; ready_viol = 0; first_cyc = -1; lastm = '0;
        cyc = 0; extra = 0; prev_stall = 1'b0; h_re = '0; h_im = '0; h_last = 1'b0;
        for (int i = 0; i < 8; i++) begin yr[i] = 0; yi[i] = 0; end
        while (cyc < 400 && extra < 3) begin
            @(negedge clk);
            hs0 = hs;
            if (prev_stall && !(s.out_valid === 1'b1 && s.out_re === h_re &&
                                s.out_im === h_im && s.out_last === h_last))
                stall_viol++;
            if (s.out_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
            if (hold && hs < 8 && s.in_ready !== 1'b0) ready_viol++;
            s.in_valid = hold && hs < 8;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 4];
                default: rdy = 1'($urandom_range(1));
            endcase
            if (hs >= 8) rdy = 1'b1;
            s.out_ready = rdy;
            prev_stall  = (s.out_valid === 1'b1) && !rdy;
            h_re = s.out_re; h_im = s.out_im; h_last = s.out_last;
            if (s.out_valid === 1'b1 && rdy) begin
                if (hs < 8) begin
                    yr[hs]    = int'(s.out_re);
                    yi[hs]    = int'(s.out_im);
                    lastm[hs] = s.out_last;
                end
                hs++;
                if (hs == 8) s.in_valid = 1'b0;
            end
            if (hs0 >= 8) extra++;
            cyc++;
        end
        timeout = (hs < 8);
        s.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (s.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_during: got %b expected 0", s.out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_during: got %b expected 0", busy); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (s.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", s.in_ready); end
        n_checks++; if (s.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", s.out_valid); end
        n_checks++; if (s.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", s.out_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (s.out_re !== 16'sd0 || s.out_im !== 16'sd0) begin n_fail++; $display("FAIL reset_out_data: got (%0d,%0d) expected (0,0)", s.out_re, s.out_im); end
    endtask

    task automatic test_impulse();
        int xr[8] = '{64, 0, 0, 0, 0, 0, 0, 0};
        int xi[8] = '{default: 0};
        int yr[8], yi[8], hs, sv, rv, fc;
        logic [7:0] lm;
        bit ok, to;
        send_frame(xr, xi, 1'b0, ok);
        collect(0, 1'b0, yr, yi, lm, hs, sv, rv, fc, to);
        n_checks++; if (ok !== 1'b1 || to !== 1'b0) begin n_fail++; $display("FAIL impulse_progress: got send_ok=%0d timeout=%0d expected 1,0", ok, to); end
        n_checks++; if (fc !== 13) begin n_fail++; $display("FAIL impulse_latency: got %0d cycles expected 13", fc); end
        n_checks++; if (hs !== 8) begin n_fail++; $display("FAIL impulse_handshakes: got %0d expected 8", hs); end
        n_checks++; if (lm !== 8'h80) begin n_fail++; $display("FAIL impulse_last: got %b expected 10000000", lm); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (yr[i] !== 8 || yi[i] !== 0) begin n_fail++; $display("FAIL impulse_sample[%0d]: got (%0d,%0d) expected (8,0)", i, yr[i], yi[i]); end
        end
        n_checks++; if (s.out_valid !== 1'b0 || s.in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL impulse_idle_after: got valid=%b ready=%b busy=%b expected 0,1,0", s.out_valid, s.in_ready, busy); end
    endtask

    task automatic test_tone();
        int xr[8] = '{0, 0, 64, 0, 0, 0, 0, 0};
        int xi[8] = '{default: 0};
        int er[8] = '{8, 0, -8, 0, 8, 0, -8, 0};
        int ei[8] = '{0, 8, 0, -8, 0, 8, 0, -8};
        int yr[8], yi[8], hs, sv, rv, fc;
        logic [7:0] lm;
        bit ok, to;
        send_frame(xr, xi, 1'b0, ok);
        collect(0, 1'b0, yr, yi, lm, hs, sv, rv, fc, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL tone_timeout: got %0d expected 0", to); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (yr[i] !== er[i] || yi[i] !== ei[i]) begin n_fail++; $display("FAIL tone_sample[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, yr[i], yi[i], er[i], ei[i]); end
        end
    endtask

    task automatic test_constant();
        int xr[8] = '{default: 8};
        int xi[8] = '{default: 0};
        int zr[8] = '{0, 64, 0, 0, 0, 0, 0, 0};
        int yr[8], yi[8], mr[8], mi[8], hs, sv, rv, fc;
        logic [7:0] lm;
        bit ok, to;
        send_frame(xr, xi, 1'b0, ok);
        collect(0, 1'b0, yr, yi, lm, hs, sv, rv, fc, to);
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (yr[i] !== (i == 0 ? 8 : 0) || yi[i] !== 0) begin n_fail++; $display("FAIL const_sample[%0d]: got (%0d,%0d) expected (%0d,0)", i, yr[i], yi[i], (i == 0 ? 8 : 0)); end
        end
        send_frame(zr, xi, 1'b0, ok);
        collect(0, 1'b0, yr, yi, lm, hs, sv, rv, fc, to);
        n_checks++; if (yr[1] < 4 || yr[1] > 6 || yi[1] < 4 || yi[1] > 6) begin n_fail++; $display("FAIL bin1_sample1: got (%0d,%0d) expected within 1 of (5,5)", yr[1], yi[1]); end
        n_checks++; if (yr[4] !== -8 || yi[4] !== 0) begin n_fail++; $display("FAIL bin1_sample4: got (%0d,%0d) expected (-8,0)", yr[4], yi[4]); end
        ref_ifft(zr, xi, mr, mi);
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (yr[i] !== mr[i] || yi[i] !== mi[i]) begin n_fail++; $display("FAIL bin1_model[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, yr[i], yi[i], mr[i], mi[i]); end
        end
    endtask

    task automatic test_backpressure();
        int xr[8], xi[8], yr[8], yi[8], mr[8], mi[8], hs, sv, rv, fc;
        logic [7:0] lm;
        bit ok, to;
        rand_frame(xr, xi);
        ref_ifft(xr, xi, mr, mi);
        send_frame(xr, xi, 1'b0, ok);
        collect(1, 1'b0, yr, yi, lm, hs, sv, rv, fc, to);
        n_checks++; if (sv !== 0) begin n_fail++; $display("FAIL bp_stall_stability: got %0d violations expected 0", sv); end
        n_checks++; if (hs !== 8) begin n_fail++; $display("FAIL bp_handshakes: got %0d expected 8", hs); end
        n_checks++; if (lm !== 8'h80) begin n_fail++; $display("FAIL bp_last: got %b expected 10000000", lm); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (yr[i] !== mr[i] || yi[i] !== mi[i]) begin n_fail++; $display("FAIL bp_sample[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, yr[i], yi[i], mr[i], mi[i]); end
        end
    endtask

    task automatic test_hold_in_valid_and_gaps();
        int xr[8], xi[8], yr[8], yi[8], gr[8], gi[8], mr[8], mi[8], hs, sv, rv, fc;
        logic [7:0] lm;
        bit ok, to;
        rand_frame(xr, xi);
        ref_ifft(xr, xi, mr, mi);
        send_frame(xr, xi, 1'b0, ok);
        collect(2, 1'b1, yr, yi, lm, hs, sv, rv, fc, to);
        n_checks++; if (rv !== 0) begin n_fail++; $display("FAIL hold_in_ready_low: got %0d cycles with in_ready high expected 0", rv); end
        n_checks++; if (hs !== 8 || sv !== 0) begin n_fail++; $display("FAIL hold_handshakes: got hs=%0d stall_viol=%0d expected 8,0", hs, sv); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (yr[i] !== mr[i] || yi[i] !== mi[i]) begin n_fail++; $display("FAIL hold_sample[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, yr[i], yi[i], mr[i], mi[i]); end
        end
        send_frame(xr, xi, 1'b1, ok);
        collect(0, 1'b0, gr, gi, lm, hs, sv, rv, fc, to);
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (gr[i] !== mr[i] || gi[i] !== mi[i]) begin n_fail++; $display("FAIL gapped_sample[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, gr[i], gi[i], mr[i], mi[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int xr[8], xi[8], yr[8], yi[8], hs, sv, rv, fc;
        int ir[8] = '{64, 0, 0, 0, 0, 0, 0, 0};
        int ii[8] = '{default: 0};
        logic [7:0] lm;
        bit ok, to;
        rand_frame(xr, xi);
        send_frame(xr, xi, 1'b0, ok);
        @(negedge clk);
        s.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || s.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got busy=%b valid=%b expected 0,0", busy, s.out_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (s.in_ready !== 1'b1 || busy !== 1'b0 || s.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_after: got ready=%b busy=%b valid=%b expected 1,0,0", s.in_ready, busy, s.out_valid); end
        send_frame(ir, ii, 1'b0, ok);
        collect(0, 1'b0, yr, yi, lm, hs, sv, rv, fc, to);
        n_checks++; if (hs !== 8 || lm !== 8'h80) begin n_fail++; $display("FAIL midreset_frame: got hs=%0d last=%b expected 8,10000000", hs, lm); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (yr[i] !== 8 || yi[i] !== 0) begin n_fail++; $display("FAIL midreset_sample[%0d]: got (%0d,%0d) expected (8,0)", i, yr[i], yi[i]); end
        end
    endtask

    task automatic test_saturation();
        int xr[8] = '{default: -32768};
        int xi[8] = '{default: -32768};
        int yr[8], yi[8], hs, sv, rv, fc;
        logic [7:0] lm;
        bit ok, to;
        send_frame(xr, xi, 1'b0, ok);
        collect(0, 1'b0, yr, yi, lm, hs, sv, rv, fc, to);
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (yr[i] !== (i == 0 ? -32768 : 0) || yi[i] !== (i == 0 ? -32768 : 0)) begin n_fail++; $display("FAIL sat_sample[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, yr[i], yi[i], (i == 0 ? -32768 : 0), (i == 0 ? -32768 : 0)); end
        end
    endtask

    task automatic test_random();
        int xr[8], xi[8], yr[8], yi[8], mr[8], mi[8], hs, sv, rv, fc;
        logic [7:0] lm;
        bit ok, to;
        for (int f = 0; f < 6; f++) begin
            rand_frame(xr, xi);
            ref_ifft(xr, xi, mr, mi);
            send_frame(xr, xi, f[0], ok);
            collect(2, 1'b0, yr, yi, lm, hs, sv, rv, fc, to);
            n_checks++; if (hs !== 8 || sv !== 0 || lm !== 8'h80) begin n_fail++; $display("FAIL rand%0d_protocol: got hs=%0d stall_viol=%0d last=%b expected 8,0,10000000", f, hs, sv, lm); end
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (yr[i] !== mr[i] || yi[i] !== mi[i]) begin n_fail++; $display("FAIL rand%0d_sample[%0d]: got (%0d,%0d) expected (%0d,%0d)", f, i, yr[i], yi[i], mr[i], mi[i]); end
            end
        end
    endtask

    initial begin
        s.in_valid  = 1'b0;
        s.in_re     = '0;
        s.in_im     = '0;
        s.out_ready = 1'b0;
        test_reset();
        test_impulse();
        test_tone();
        test_constant();
        test_backpressure();
        test_hold_in_valid_and_gaps();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
